// File: rtl/cfnp_pkg.sv
// Shared constants, FSM state type and rounding helper for the CFNP
// feature-recalibration datapath.
package cfnp_pkg;

  localparam int FR_N_OUT = 5;
  localparam int FR_N_IN  = 21;
  localparam int FR_FRAC  = 10;
  localparam int FR_ACC_W = 40;

  typedef enum logic [2:0] {
    FR_IDLE  = 3'd0,
    FR_RUN   = 3'd1,
    FR_DRAIN = 3'd2,
    FR_EMIT  = 3'd3,
    FR_FIN   = 3'd4
  } fr_seq_state_t;

  // Round half up on the fixed-point boundary, then clamp to the int16 range.
  function automatic logic signed [15:0] sat_round16(input longint acc, input int frac);
    longint r;
    r = (acc + (longint'(1) <<< (frac - 1))) >>> frac;
    if (r > longint'(32767)) begin
      sat_round16 = 16'sh7FFF;
    end else if (r < -longint'(32768)) begin
      sat_round16 = 16'sh8000;
    end else begin
      sat_round16 = r[15:0];
    end
  endfunction

endpackage

// File: rtl/fr_dual_mac.sv
// Twin multiply-accumulate lane for the mean and variance weights, with
// product registers, wide accumulators and round/saturate on the result.
module fr_dual_mac
  import cfnp_pkg::*;
#(
  parameter int FRAC  = FR_FRAC,
  parameter int ACC_W = FR_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic signed [15:0] x_i,
  input  logic signed [15:0] wm_i,
  input  logic signed [15:0] wv_i,
  output logic signed [15:0] res_m_o,
  output logic signed [15:0] res_v_o
);

  logic signed [31:0]      p_m_q, p_m_d;
  logic signed [31:0]      p_v_q, p_v_d;
  logic                    p_vld_q, p_vld_d;
  logic signed [ACC_W-1:0] acc_m_q, acc_m_d;
  logic signed [ACC_W-1:0] acc_v_q, acc_v_d;

  always_comb begin
    p_m_d   = p_m_q;
    p_v_d   = p_v_q;
    p_vld_d = en;
    if (en) begin
      p_m_d = x_i * wm_i;
      p_v_d = x_i * wv_i;
    end
  end

  // A clear always wins: it only coincides with idle product slots anyway.
  always_comb begin
    acc_m_d = acc_m_q;
    acc_v_d = acc_v_q;
    if (clr) begin
      acc_m_d = '0;
      acc_v_d = '0;
    end else if (p_vld_q) begin
      acc_m_d = acc_m_q + {{(ACC_W-32){p_m_q[31]}}, p_m_q};
      acc_v_d = acc_v_q + {{(ACC_W-32){p_v_q[31]}}, p_v_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_m_q   <= '0;
      p_v_q   <= '0;
      p_vld_q <= 1'b0;
      acc_m_q <= '0;
      acc_v_q <= '0;
    end else begin
      p_m_q   <= p_m_d;
      p_v_q   <= p_v_d;
      p_vld_q <= p_vld_d;
      acc_m_q <= acc_m_d;
      acc_v_q <= acc_v_d;
    end
  end

  assign res_m_o = sat_round16(longint'(acc_m_q), FRAC);
  assign res_v_o = sat_round16(longint'(acc_v_q), FRAC);

endmodule

// File: rtl/fr_weight_sequencer.sv
// Walks the FR weight memory row by row, feeding the dual MAC and emitting
// one rounded mean/variance result pair per output filter.
module fr_weight_sequencer
  import cfnp_pkg::*;
#(
  parameter int N_OUT = FR_N_OUT,
  parameter int N_IN  = FR_N_IN,
  parameter int FRAC  = FR_FRAC,
  parameter int ACC_W = FR_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [4:0]         x_addr,
  input  logic signed [15:0] x_data,
  output logic               w_start,
  output logic [2:0]         w_out_m,
  output logic [2:0]         w_out_v,
  output logic [4:0]         w_in,
  input  logic signed [15:0] w_m,
  input  logic signed [15:0] w_v,
  input  logic               w_done,
  output logic [2:0]         out_idx,
  output logic signed [15:0] out_m,
  output logic signed [15:0] out_v,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  fr_seq_state_t state_q, state_d;
  logic [2:0]    o_q, o_d;
  logic [4:0]    i_q, i_d;
  logic          mac_clr;
  logic          mac_en;

  logic signed [15:0] res_m, res_v;
  logic signed [15:0] out_m_q, out_m_d;
  logic signed [15:0] out_v_q, out_v_d;
  logic [2:0]         out_idx_q, out_idx_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    i_d     = i_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      FR_IDLE: begin
        if (start) begin
          state_d = FR_RUN;
          o_d     = '0;
          i_d     = '0;
          mac_clr = 1'b1;
        end
      end
      FR_RUN: begin
        if (w_done) begin
          mac_en = 1'b1;
          if (i_q == 5'(N_IN - 1)) begin
            state_d = FR_DRAIN;
          end else begin
            i_d = i_q + 5'd1;
          end
        end
      end
      FR_DRAIN: state_d = FR_EMIT;
      FR_EMIT: begin
        mac_clr = 1'b1;
        i_d     = '0;
        if (o_q == 3'(N_OUT - 1)) begin
          state_d = FR_FIN;
        end else begin
          o_d     = o_q + 3'd1;
          state_d = FR_RUN;
        end
      end
      FR_FIN:  state_d = FR_IDLE;
      default: state_d = FR_IDLE;
    endcase
  end

  // Results are captured on the EMIT edge and then held until the next EMIT.
  always_comb begin
    out_m_d     = out_m_q;
    out_v_d     = out_v_q;
    out_idx_d   = out_idx_q;
    out_valid_d = (state_q == FR_EMIT);
    done_d      = (state_q == FR_FIN);
    if (state_q == FR_EMIT) begin
      out_m_d   = res_m;
      out_v_d   = res_v;
      out_idx_d = o_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FR_IDLE;
      o_q         <= '0;
      i_q         <= '0;
      out_m_q     <= '0;
      out_v_q     <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      i_q         <= i_d;
      out_m_q     <= out_m_d;
      out_v_q     <= out_v_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  fr_dual_mac #(
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (mac_clr),
    .en      (mac_en),
    .x_i     (x_data),
    .wm_i    (w_m),
    .wv_i    (w_v),
    .res_m_o (res_m),
    .res_v_o (res_v)
  );

  assign x_addr    = i_q;
  assign w_in      = i_q;
  assign w_out_m   = o_q;
  assign w_out_v   = o_q;
  assign w_start   = (state_q == FR_RUN);
  assign busy      = (state_q != FR_IDLE);
  assign out_m     = out_m_q;
  assign out_v     = out_v_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fr_weight_sequencer.sv
// Directed and randomized layer runs of fr_weight_sequencer against a
// schedule-and-dot-product reference model.
module tb_fr_weight_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, w_done;
  logic [4:0]         x_addr, w_in;
  logic [2:0]         w_out_m, w_out_v, out_idx;
  logic signed [15:0] x_data, w_m, w_v, out_m, out_v;
  logic               w_start, out_valid, busy, done;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] wmMem [5][21];
  logic signed [15:0] wvMem [5][21];
  logic signed [15:0] feat  [21];
  int                 stallMap [5][21];

  bit     runEdge [1024];
  bit     lowArr  [1024];
  int     expO    [1024];
  int     expI    [1024];
  int     emitEdge [5];
  int     doneEdge;
  longint expM [5];
  longint expV [5];

  fr_weight_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_addr    (x_addr),
    .x_data    (x_data),
    .w_start   (w_start),
    .w_out_m   (w_out_m),
    .w_out_v   (w_out_v),
    .w_in      (w_in),
    .w_m       (w_m),
    .w_v       (w_v),
    .w_done    (w_done),
    .out_idx   (out_idx),
    .out_m     (out_m),
    .out_v     (out_v),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  // Combinational memories behind the address ports
  always_comb begin
    x_data = '0;
    w_m    = '0;
    w_v    = '0;
    if (int'(x_addr) < 21) x_data = feat[int'(x_addr)];
    if (int'(w_out_m) < 5 && int'(w_in) < 21) begin
      w_m = wmMem[int'(w_out_m)][int'(w_in)];
      w_v = wvMem[int'(w_out_m)][int'(w_in)];
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint refRound(input longint a);
    longint num, q;
    num = a + 512;
    if (num >= 0) q = num / 1024;
    else q = -((-num + 1023) / 1024);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  // Cycle timeline of one layer, indexed by clock edge after the start edge
  task automatic buildSchedule();
    int k;
    for (int n = 0; n < 1024; n++) begin
      runEdge[n] = 1'b0;
      lowArr[n]  = 1'b0;
      expO[n]    = 0;
      expI[n]    = 0;
    end
    k = 1;
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 21; i++) begin
        for (int s = 0; s < stallMap[o][i]; s++) begin
          runEdge[k] = 1'b1; lowArr[k] = 1'b1; expO[k] = o; expI[k] = i; k++;
        end
        runEdge[k] = 1'b1; lowArr[k] = 1'b0; expO[k] = o; expI[k] = i; k++;
      end
      k++;
      emitEdge[o] = k;
      k++;
    end
    doneEdge = emitEdge[4] + 1;
    for (int o = 0; o < 5; o++) begin
      longint am, av;
      am = 0;
      av = 0;
      for (int i = 0; i < 21; i++) begin
        am += longint'(feat[i]) * longint'(wmMem[o][i]);
        av += longint'(feat[i]) * longint'(wvMem[o][i]);
      end
      expM[o] = refRound(am);
      expV[o] = refRound(av);
    end
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_valid"}, longint'(out_valid), 0);
    check({tag, "_wstart"}, longint'(w_start), 0);
    check({tag, "_xaddr"}, longint'(x_addr), 0);
    check({tag, "_win"}, longint'(w_in), 0);
    check({tag, "_wout"}, longint'(w_out_m), 0);
    check({tag, "_idx"}, longint'(out_idx), 0);
    check({tag, "_m"}, longint'(out_m), 0);
    check({tag, "_v"}, longint'(out_v), 0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int abortAt, input int startPulseAt,
                               output longint got0m, output longint got0v,
                               output int doneAt);
    int k, nValid, nDone;
    got0m  = -99999;
    got0v  = -99999;
    doneAt = -1;
    buildSchedule();
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    k      = 0;
    nValid = 0;
    nDone  = 0;
    check("busy_after_start", longint'(busy), 1);
    while (k < doneEdge + 3 && k < 1000) begin
      if (runEdge[k+1]) begin
        check("w_start", longint'(w_start), 1);
        check("w_in", longint'(w_in), longint'(expI[k+1]));
        check("x_addr", longint'(x_addr), longint'(expI[k+1]));
        check("w_out_m", longint'(w_out_m), longint'(expO[k+1]));
        check("w_out_v", longint'(w_out_v), longint'(expO[k+1]));
      end
      w_done = runEdge[k+1] ? !lowArr[k+1] : 1'($urandom);
      start  = (startPulseAt > 0 && (k + 1 == startPulseAt || k + 1 == doneEdge));
      if (abortAt > 0 && k + 1 == abortAt) begin
        rst   = 1'b1;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      k++;
      rst   = 1'b0;
      start = 1'b0;
      if (abortAt > 0 && k == abortAt) begin
        int stray;
        checkZero("abort");
        stray = 0;
        w_done = 1'b1;
        repeat (30) begin
          @(posedge clk);
          #1;
          if (out_valid || done) stray++;
        end
        check("abort_no_output", longint'(stray), 0);
        check("abort_idle", longint'(busy), 0);
        return;
      end
      if (out_valid) begin
        if (nValid < 5) begin
          check("valid_edge", longint'(k), longint'(emitEdge[nValid]));
          check("out_idx", longint'(out_idx), longint'(nValid));
          check("out_m", longint'(out_m), expM[nValid]);
          check("out_v", longint'(out_v), expV[nValid]);
          if (nValid == 0) begin
            got0m = longint'(out_m);
            got0v = longint'(out_v);
          end
        end
        nValid++;
      end
      if (done) begin
        check("done_edge", longint'(k), longint'(doneEdge));
        check("busy_at_done", longint'(busy), 0);
        doneAt = k;
        nDone++;
      end
    end
    check("valid_count", longint'(nValid), 5);
    check("done_count", longint'(nDone), 1);
    check("idle_after_layer", longint'(busy), 0);
  endtask

  task automatic clearStalls();
    for (int o = 0; o < 5; o++)
      for (int i = 0; i < 21; i++) stallMap[o][i] = 0;
  endtask

  task automatic setFeat(input logic signed [15:0] val);
    for (int i = 0; i < 21; i++) feat[i] = val;
  endtask

  task automatic randomWeights();
    for (int o = 1; o < 5; o++)
      for (int i = 0; i < 21; i++) begin
        wmMem[o][i] = 16'($urandom);
        wvMem[o][i] = 16'($urandom);
      end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint g0m, g0v;
    int     dAt;
    rst    = 1'b1;
    start  = 1'b0;
    w_done = 1'b0;
    for (int i = 0; i < 21; i++) begin
      wmMem[0][i] = '0;
      wvMem[0][i] = '0;
    end
    wmMem[0][0] = 16'sd463;
    wmMem[0][1] = 16'sd1450;
    wvMem[0][0] = 16'sd23;
    wvMem[0][1] = 16'sd538;
    randomWeights();
    clearStalls();
    setFeat(16'sd0);

    idleCycles(3);
    checkZero("reset");
    start = 1'b1;
    idleCycles(1);
    check("reset_beats_start", longint'(busy), 0);
    rst   = 1'b0;
    start = 1'b0;
    idleCycles(2);

    setFeat(16'sd1024);
    applyStimulus(0, 0, g0m, g0v, dAt);
    check("unity_m0", g0m, 1913);
    check("unity_v0", g0v, 561);
    check("unity_done", longint'(dAt), 116);
    idleCycles(2);

    setFeat(-16'sd32768);
    applyStimulus(0, 0, g0m, g0v, dAt);
    check("neg_sat_m0", g0m, -32768);
    check("neg_v0", g0v, -17952);
    idleCycles(2);

    setFeat(16'sd1024);
    stallMap[2][7] = 3;
    applyStimulus(0, 0, g0m, g0v, dAt);
    check("stall_m0", g0m, 1913);
    check("stall_done", longint'(dAt), 119);
    clearStalls();
    idleCycles(2);

    applyStimulus(3 * 23 + 5, 0, g0m, g0v, dAt);
    idleCycles(2);
    applyStimulus(0, 0, g0m, g0v, dAt);
    check("after_abort_m0", g0m, 1913);
    idleCycles(2);

    applyStimulus(0, 10, g0m, g0v, dAt);
    idleCycles(2);

    setFeat(16'sd0);
    feat[0] = 16'sd512;
    applyStimulus(0, 0, g0m, g0v, dAt);
    check("round_m0", g0m, 232);
    check("round_v0", g0v, 12);
    idleCycles(2);

    for (int r = 0; r < 3; r++) begin
      randomWeights();
      for (int i = 0; i < 21; i++) feat[i] = 16'($urandom);
      for (int o = 0; o < 5; o++)
        for (int i = 0; i < 21; i++)
          stallMap[o][i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      applyStimulus(0, 0, g0m, g0v, dAt);
      idleCycles(3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fr_weight_sequencer.md
# fr_weight_sequencer

Sequences the feature-recalibration weight memory for one CFNP FR layer. On `start` it walks every (output filter, input filter) pair, reads the mean (`m`) and variance (`v`) weights and the matching input feature, and accumulates two dot products per output filter. It emits one rounded, saturated Q-format result pair per output filter. It sits between the FR feature buffer and the downstream normalisation stage.

## Interface
Parameters:
- `N_OUT`, 5, number of output filters (rows of the weight memory).
- `N_IN`, 21, number of input filters (columns).
- `FRAC`, 10, fractional bits of the weights, features and results.
- `ACC_W`, 40, accumulator width.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request; accepted only in IDLE.
- `x_addr` output 5: feature-buffer index; equals the current input filter.
- `x_data` input 16 signed: feature, valid in the same cycle as `x_addr` (combinational read).
- `w_start` output 1: weight-memory enable.
- `w_out_m` output 3, `w_out_v` output 3: weight row select; both always equal the current output filter.
- `w_in` output 5: weight column select.
- `w_m` input 16 signed, `w_v` input 16 signed: weight data, combinational.
- `w_done` input 1: weight data valid.
- `out_idx` output 3: output filter of the current result.
- `out_m` output 16 signed, `out_v` output 16 signed: results.
- `out_valid` output 1: one-cycle pulse when `out_m`/`out_v`/`out_idx` are valid.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at the end of the layer.

## Operation
States: IDLE, RUN, DRAIN, EMIT, FIN.
- **IDLE:**
  - `start`=1 → RUN. Output counter `o`=0, input counter `i`=0, both accumulators cleared.
  - `start` is ignored in all other states.
- **RUN:**
  - `w_start`=1; addresses are `o` and `i`.
  - If `w_done`=1: register `p_m = x_data*w_m` and `p_v = x_data*w_v` (32-bit signed) with `p_vld`=1, then `i++`.
  - If `w_done`=0: stall. Hold `i`, `p_vld`=0.
  - Accepting `i`=`N_IN`-1 → DRAIN.
- **Accumulation:** every cycle with `p_vld`=1, `acc_m += p_m` and `acc_v += p_v`, sign-extended to `ACC_W`.
- **DRAIN:** one cycle; the last product is accumulated. `w_start`=0. → EMIT.
- **EMIT:**
  - Result per accumulator: `(acc + 2^(FRAC-1)) >>> FRAC` (round half up), saturated to [-32768, 32767].
  - Register the results with `out_idx`=`o`; `out_valid`=1 for this cycle only.
  - Clear both accumulators and set `i`=0.
  - If `o`=`N_OUT`-1 → FIN; otherwise `o++` and → RUN.
- **FIN:** `done`=1 for one cycle → IDLE.
- `out_m`, `out_v` and `out_idx` hold their last values until the next EMIT.
- `rst` is honoured in any state, including mid-RUN:
  - Next state IDLE.
  - Counters, accumulators, `p_vld`, all outputs and addresses are 0.
  - No `out_valid` or `done` is produced for the aborted layer.

## Timing
- Reset value of every output: 0.
- Per output filter with no stalls: `N_IN` RUN + 1 DRAIN + 1 EMIT = 23 cycles.
- Full layer with no stalls: 5×23 = 115 cycles, plus 1 FIN cycle.
  - First `out_valid` comes 23 cycles after the cycle in which `start` is sampled.
  - `done` comes 1 cycle after the last `out_valid`.
- Each `w_done`=0 cycle adds one cycle. There is no timeout.
- `start` asserted in the same cycle as `rst`: reset wins.
- `start` asserted during FIN: ignored. A new start is accepted no earlier than the cycle after `done`.

## Structure
- Shared package `cfnp_pkg`:
  - `FR_N_OUT`=5, `FR_N_IN`=21, `FR_FRAC`=10.
  - State enum `fr_seq_state_t`.
  - Function `sat_round16(acc, frac)`.
- One sub-module: `fr_dual_mac`. It holds the product registers, both accumulators, and round/saturate, with `clr` and `en` inputs. The FSM and counters stay in the top module.

## Test plan
1. All `x_data`=1024 (1.0), `w_done` tied high → `out_idx`=0 gives `out_m`=1913, `out_v`=561. Five `out_valid` pulses at cycles 23, 46, 69, 92, 115 after start. `done` at cycle 116.
2. All `x_data`=-32768 → filter 0 gives `out_m`=-32768 (saturated from -61216) and `out_v`=-17952.
3. `w_done` low for 3 cycles at `i`=7 of filter 2 → `i` and addresses hold while low. Results identical to scenario 1. `done` arrives 3 cycles late.
4. `rst` pulsed during RUN of filter 3 → all outputs 0 the next cycle, `busy`=0, no `done`. A following `start` yields the full 5-result sequence from `out_idx`=0.
5. `start` pulsed during RUN and during FIN → ignored; exactly one `done` per accepted start.
6. Rounding: one nonzero feature, `x_data`=512 at `i`=0, all others 0, filter 0 (`w_m`=463) → 463×512/1024 = 231.5 gives `out_m`=232; `w_v`=23 gives 11.5, so `out_v`=12.
